// File: rtl/decimator_pkg.sv
// decimator_pkg: shared defaults and the phase-counter width helper
package decimator_pkg;
  localparam int DEFAULT_DATA_W = 12;
  localparam int DEFAULT_DECIM_FACTOR = 512;
  function automatic int ctr_width(input int decim_factor);
    return $clog2(decim_factor);
  endfunction
endpackage

// File: rtl/decim_phase_ctr.sv
// decim_phase_ctr: free-running wrap-around phase counter with terminal-count flag
module decim_phase_ctr #(
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst,
  output logic tc
);
  logic [W-1:0] cnt;
  // Power-of-two period, so the natural binary wrap gives a seamless restart
  always_ff @(posedge clk)
    cnt <= rst ? '0 : cnt + 1'b1;
  assign tc = &cnt;
endmodule

// File: rtl/decimator.sv
// decimator: sample-and-hold decimator; define DECIMATOR_VALID_EN to add the data_valid strobe
module decimator
  import decimator_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DECIM_FACTOR = DEFAULT_DECIM_FACTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
`ifdef DECIMATOR_VALID_EN
  output logic              data_valid,
`endif
  output logic [DATA_W-1:0] data_out
);
  localparam int CW = ctr_width(DECIM_FACTOR);
  if (DECIM_FACTOR < 2 || DECIM_FACTOR > 65536 || (DECIM_FACTOR & (DECIM_FACTOR - 1)) != 0) begin : g_bad_factor
    $fatal(1, "decimator: DECIM_FACTOR must be a power of two in [2, 65536]");
  end
  logic tc;
  decim_phase_ctr #(.W(CW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .tc (tc)
  );
  // Capture on the last phase of each period; reset wins over a capture
  always_ff @(posedge clk)
    data_out <= rst ? '0 : tc ? data_in : data_out;
`ifdef DECIMATOR_VALID_EN
  // Strobe is high for the cycle following each capture edge
  always_ff @(posedge clk)
    data_valid <= !rst && tc;
`endif
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: directed-vector bench with a cycle-count model for decimator
module tb_decimator;
  localparam int F  = 512;
  localparam int F2 = 2;
  logic clk = 0;
  logic rst = 1;
  logic [11:0] data_in = '0;
  logic [11:0] data_out, data_out2;
`ifdef DECIMATOR_VALID_EN
  logic data_valid, data_valid2;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decimator #(.DATA_W(12), .DECIM_FACTOR(F)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
`ifdef DECIMATOR_VALID_EN
    .data_valid(data_valid),
`endif
    .data_out(data_out)
  );

  decimator #(.DATA_W(12), .DECIM_FACTOR(F2)) dut2 (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
`ifdef DECIMATOR_VALID_EN
    .data_valid(data_valid2),
`endif
    .data_out(data_out2)
  );

  // Model: count non-reset cycles; every multiple of the factor captures data_in
  int n = 0, n2 = 0;
  logic [11:0] exp_d = '0, exp_d2 = '0;
  logic exp_v = 0, exp_v2 = 0;
  logic started = 0;

  always @(posedge clk) begin
    if (rst) begin
      n <= 0; n2 <= 0; exp_d <= '0; exp_d2 <= '0; exp_v <= 0; exp_v2 <= 0; started <= 1;
    end else begin
      n <= n + 1;
      n2 <= n2 + 1;
      exp_v <= ((n + 1) % F == 0);
      exp_v2 <= ((n2 + 1) % F2 == 0);
      if ((n + 1) % F == 0) exp_d <= data_in;
      if ((n2 + 1) % F2 == 0) exp_d2 <= data_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk)
    if (started) begin
      chk("model_out", {20'd0, data_out}, {20'd0, exp_d});
      chk("model_out_f2", {20'd0, data_out2}, {20'd0, exp_d2});
`ifdef DECIMATOR_VALID_EN
      chk("model_valid", {31'd0, data_valid}, {31'd0, exp_v});
      chk("model_valid_f2", {31'd0, data_valid2}, {31'd0, exp_v2});
`endif
    end

  task automatic tick(input logic r, input logic [11:0] d);
    rst = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] v;
    repeat (2) tick(1'b1, 12'h000);
    chk("reset_out", {20'd0, data_out}, 32'd0);
    // Ramp: data_in equals the cycle index starting at 0
    for (int i = 0; i < 1536; i++) begin
      tick(1'b0, i[11:0]);
      if (i == 1) chk("f2_first", {20'd0, data_out2}, 32'd1);
      if (i == 2) chk("f2_hold", {20'd0, data_out2}, 32'd1);
      if (i == 3) chk("f2_second", {20'd0, data_out2}, 32'd3);
      if (i == 510) chk("ramp_pre", {20'd0, data_out}, 32'd0);
      if (i == 511) chk("ramp_512", {20'd0, data_out}, 32'd511);
      if (i == 1023) chk("ramp_1024", {20'd0, data_out}, 32'd1023);
      if (i == 1535) chk("ramp_1536", {20'd0, data_out}, 32'd1535);
`ifdef DECIMATOR_VALID_EN
      if (i == 511) chk("valid_pulse", {31'd0, data_valid}, 32'd1);
      if (i == 512) chk("valid_drop", {31'd0, data_valid}, 32'd0);
`endif
    end
    // Hold: constant 0xABC, then 0x123 into the next period
    repeat (2) tick(1'b1, 12'h000);
    chk("reset_clears", {20'd0, data_out}, 32'd0);
    for (int i = 1; i <= 812; i++) begin
      tick(1'b0, i <= 512 ? 12'hABC : 12'h123);
      if (i == 511) chk("hold_pre", {20'd0, data_out}, 32'd0);
      if (i == 512) chk("hold_cap", {20'd0, data_out}, 32'hABC);
      if (i == 812) chk("hold_keep", {20'd0, data_out}, 32'hABC);
    end
    // Mid-period reset 300 cycles into the second period
    tick(1'b1, 12'h123);
    chk("mid_rst", {20'd0, data_out}, 32'd0);
    for (int i = 1; i <= 512; i++) begin
      tick(1'b0, i[11:0] + 12'h040);
      if (i == 511) chk("mid_rst_pre", {20'd0, data_out}, 32'd0);
      if (i == 512) chk("mid_rst_cap", {20'd0, data_out}, 32'h240);
    end
    // Reset on the would-be capture edge takes priority
    for (int i = 1; i <= 511; i++) tick(1'b0, 12'hFFF);
    chk("prio_pre", {20'd0, data_out}, 32'h240);
    tick(1'b1, 12'hFFF);
    chk("rst_priority", {20'd0, data_out}, 32'd0);
    // Wrap: ramp from 3000 passing through 0xFFF
    for (int i = 0; i < 5000; i++) begin
      v = 12'(i + 3000);
      tick(1'b0, v);
      if (i == 2047) chk("wrap_2048", {20'd0, data_out}, 32'd951);
      if (i == 4607) chk("wrap_4608", {20'd0, data_out}, 32'd3511);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
